move_draw_controller: RTL and testbench

- Moore FSM that sequences the sprite datapath for the button-driven plotting design.
- Each frame it waits for the frame timer, erases the sprite at the old position, pulses the position counters once, then redraws the sprite at the new position.
- It scans the sprite one pixel per clock as a BOX_W x BOX_H block of offsets. The datapath adds these offsets to xpos/ypos and selects the pixel colour with erase.

---
 rtl/move_draw_pkg.sv | 59 +++++
 rtl/box_scan_counter.sv | 61 ++++++
 rtl/move_draw_controller.sv | 72 +++++++
 tb/tb_move_draw_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/move_draw_pkg.sv
// Shared types and constants for the sprite move/draw sequencer.
// Also sizes the datapath offset adders through the *_DEF constants.
package move_draw_pkg;

  localparam int BOX_W_DEF    = 4;
  localparam int BOX_H_DEF    = 4;
  localparam int OFF_BITS_DEF = 2;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_DRAW  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ERASE = 3'd3,
    ST_MOVE  = 3'd4
  } state_e;

  localparam logic [2:0] S_START = ST_START;
  localparam logic [2:0] S_DRAW  = ST_DRAW;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_ERASE = ST_ERASE;
  localparam logic [2:0] S_MOVE  = ST_MOVE;

  typedef struct packed {
    logic timer_en;
    logic pos_count_en;
    logic plot_en;
    logic erase;
    logic busy;
  } ctrl_t;

  // Moore decode: a function of the registered state only
  function automatic ctrl_t decode_ctrl(
    input logic [2:0] s
  );
    ctrl_t c;
    c = '0;
    unique case (1'b1)
      (s == S_DRAW): begin
        c.plot_en = 1'b1;
        c.busy    = 1'b1;
      end
      (s == S_WAIT): begin
        c.timer_en = 1'b1;
      end
      (s == S_ERASE): begin
        c.plot_en = 1'b1;
        c.erase   = 1'b1;
        c.busy    = 1'b1;
      end
      (s == S_MOVE): begin
        c.pos_count_en = 1'b1;
        c.busy         = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/box_scan_counter.sv
// Raster scan of a BOX_W x BOX_H sprite, one pixel per enabled clock.
// Wraps to (0,0) after the last pixel so the next scan starts clean.
import move_draw_pkg::*;

module box_scan_counter #(
  parameter int BOX_W    = BOX_W_DEF,
  parameter int BOX_H    = BOX_H_DEF,
  parameter int OFF_BITS = OFF_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  output logic [OFF_BITS-1:0] x_off,
  output logic [OFF_BITS-1:0] y_off,
  output logic                last
);

  localparam logic [OFF_BITS-1:0] X_MAX = OFF_BITS'(BOX_W - 1);
  localparam logic [OFF_BITS-1:0] Y_MAX = OFF_BITS'(BOX_H - 1);
  localparam logic [OFF_BITS-1:0] ONE   = OFF_BITS'(1);

  logic [OFF_BITS-1:0] x_q, x_d;
  logic [OFF_BITS-1:0] y_q, y_d;
  logic                x_end;
  logic                y_end;

  assign x_end = (x_q == X_MAX);
  assign y_end = (y_q == Y_MAX);
  assign last  = x_end & y_end;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr || (en && last)) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_q + ONE;
      end else begin
        x_d = x_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_off = x_q;
  assign y_off = y_q;

endmodule

// File: rtl/move_draw_controller.sv
// Frame sequencer: wait for timer, erase sprite, step position, redraw.
// Outputs decode from registered state and offsets only.
import move_draw_pkg::*;

module move_draw_controller #(
  parameter int BOX_W    = BOX_W_DEF,
  parameter int BOX_H    = BOX_H_DEF,
  parameter int OFF_BITS = OFF_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                timer_done,
  output logic                timer_en,
  output logic                pos_count_en,
  output logic                plot_en,
  output logic                erase,
  output logic [OFF_BITS-1:0] x_off,
  output logic [OFF_BITS-1:0] y_off,
  output logic                busy
);

  logic [2:0] state_q, state_d;
  logic       scan_en;
  logic       scan_clr;
  logic       scan_last;
  ctrl_t      ctrl;

  assign scan_en  = (state_q == S_DRAW) || (state_q == S_ERASE);
  assign scan_clr = ~scan_en;

  box_scan_counter #(
    .BOX_W    (BOX_W),
    .BOX_H    (BOX_H),
    .OFF_BITS (OFF_BITS)
  ) u_scan (
    .clk   (clk),
    .rst_n (reset),
    .clr   (scan_clr),
    .en    (scan_en),
    .x_off (x_off),
    .y_off (y_off),
    .last  (scan_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_START: state_d = S_DRAW;
      S_DRAW:  if (scan_last) state_d = S_WAIT;
      S_WAIT:  if (timer_done) state_d = S_ERASE;
      S_ERASE: if (scan_last) state_d = S_MOVE;
      S_MOVE:  state_d = S_DRAW;
      default: state_d = S_START;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_START;
    end else begin
      state_q <= state_d;
    end
  end

  assign ctrl         = decode_ctrl(state_q);
  assign timer_en     = ctrl.timer_en;
  assign pos_count_en = ctrl.pos_count_en;
  assign plot_en      = ctrl.plot_en;
  assign erase        = ctrl.erase;
  assign busy         = ctrl.busy;

endmodule

// File: tb/tb_move_draw_controller.sv
// Bench for move_draw_controller: 4x4, 3x2 and 1x1 sprites side by side.
// Model tracks each sprite as a phase plus a linear pixel index.
module tb_move_draw_controller;

  localparam int P_START = 0;
  localparam int P_DRAW  = 1;
  localparam int P_WAIT  = 2;
  localparam int P_ERASE = 3;
  localparam int P_MOVE  = 4;

  localparam int MW [3] = '{4, 3, 1};
  localparam int MH [3] = '{4, 2, 1};

  localparam logic [1:0] EX4 [16] = '{
    2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
    2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  localparam logic [1:0] EY4 [16] = '{
    2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
  localparam logic [1:0] EX3 [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
  localparam logic [1:0] EY3 [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};

  logic       clk = 1'b0;
  logic       reset;
  logic       timer_done;
  logic [2:0] te, pc, pl, er, bz;
  logic [1:0] xa, ya, xb, yb;
  logic       xc, yc;

  int n_chk = 0;
  int n_err = 0;
  int m_ph [3];
  int m_k  [3];
  int pcnt;

  always #5 clk = ~clk;

  move_draw_controller #(.BOX_W(4), .BOX_H(4), .OFF_BITS(2)) dut44 (
    .clk(clk), .reset(reset), .timer_done(timer_done),
    .timer_en(te[0]), .pos_count_en(pc[0]), .plot_en(pl[0]),
    .erase(er[0]), .x_off(xa), .y_off(ya), .busy(bz[0]));

  move_draw_controller #(.BOX_W(3), .BOX_H(2), .OFF_BITS(2)) dut32 (
    .clk(clk), .reset(reset), .timer_done(timer_done),
    .timer_en(te[1]), .pos_count_en(pc[1]), .plot_en(pl[1]),
    .erase(er[1]), .x_off(xb), .y_off(yb), .busy(bz[1]));

  move_draw_controller #(.BOX_W(1), .BOX_H(1), .OFF_BITS(1)) dut11 (
    .clk(clk), .reset(reset), .timer_done(timer_done),
    .timer_en(te[2]), .pos_count_en(pc[2]), .plot_en(pl[2]),
    .erase(er[2]), .x_off(xc), .y_off(yc), .busy(bz[2]));

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // {timer_en, pos_count_en, plot_en, erase, busy, x[1:0], y[1:0]}
  function automatic logic [8:0] expv(input int i);
    int ph;
    int k;
    int x;
    int y;
    ph = m_ph[i];
    k  = m_k[i];
    x  = k % MW[i];
    y  = k / MW[i];
    return {ph == P_WAIT, ph == P_MOVE,
            ph == P_DRAW || ph == P_ERASE, ph == P_ERASE,
            ph == P_DRAW || ph == P_ERASE || ph == P_MOVE,
            2'(x), 2'(y)};
  endfunction

  function automatic logic [8:0] actv(input int i);
    logic [8:0] v;
    case (i)
      0: v = {te[0], pc[0], pl[0], er[0], bz[0], xa, ya};
      1: v = {te[1], pc[1], pl[1], er[1], bz[1], xb, yb};
      default: v = {te[2], pc[2], pl[2], er[2], bz[2],
                    1'b0, xc, 1'b0, yc};
    endcase
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        m_ph[i] <= P_START;
        m_k[i]  <= 0;
      end else begin
        case (m_ph[i])
          P_START: begin m_ph[i] <= P_DRAW; m_k[i] <= 0; end
          P_DRAW:
            if (m_k[i] == MW[i] * MH[i] - 1) begin
              m_ph[i] <= P_WAIT; m_k[i] <= 0;
            end else m_k[i] <= m_k[i] + 1;
          P_WAIT:
            if (timer_done) begin m_ph[i] <= P_ERASE; m_k[i] <= 0; end
          P_ERASE:
            if (m_k[i] == MW[i] * MH[i] - 1) begin
              m_ph[i] <= P_MOVE; m_k[i] <= 0;
            end else m_k[i] <= m_k[i] + 1;
          default: begin m_ph[i] <= P_DRAW; m_k[i] <= 0; end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++)
      chk($sformatf("outputs_dut%0d", i), 32'(actv(i)), 32'(expv(i)));
  end

  initial begin
    reset = 1'b0;
    timer_done = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_zero_dut%0d", i), 32'(actv(i)), 32'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;

    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("draw44_order", {28'd0, pl[0], er[0], xa, ya},
          {28'd0, 1'b1, 1'b0, EX4[k], EY4[k]});
      if (k < 6)
        chk("draw32_order", {28'd0, pl[1], xb, yb},
            {28'd0, 1'b1, EX3[k], EY3[k]});
      if (k == 6)
        chk("draw32_done", {30'd0, te[1], pl[1]}, 32'd2);
      if (k == 1)
        chk("draw11_done", {30'd0, te[2], pl[2]}, 32'd2);
    end
    @(negedge clk);
    chk("wait44_entry", {30'd0, te[0], pl[0]}, 32'd2);

    #1 timer_done = 1'b1;
    pcnt = 0;
    for (int n = 0; n < 34; n++) begin
      @(negedge clk);
      pcnt += int'(pc[0]);
      if (n == 0) chk("erase11", {30'd0, pl[2], er[2]}, 32'd3);
      if (n == 1) chk("move11", 32'(pc[2]), 32'd1);
      if (n == 2) chk("draw11", {30'd0, pl[2], er[2]}, 32'd2);
      if (n == 3) chk("wait11", 32'(te[2]), 32'd1);
      if (n == 12) chk("lat32_early", 32'(te[1]), 32'd0);
      if (n == 13) chk("lat32", 32'(te[1]), 32'd1);
      if (n == 16) chk("move44", 32'(pc[0]), 32'd1);
      if (n == 32) chk("lat44_early", 32'(te[0]), 32'd0);
      if (n == 33) chk("lat44", 32'(te[0]), 32'd1);
      if (n == 0) #1 timer_done = 1'b0;
    end
    chk("pulses44_single", 32'(pcnt), 32'd1);

    #1 timer_done = 1'b1;
    pcnt = 0;
    for (int n = 0; n < 34; n++) begin
      @(negedge clk);
      pcnt += int'(pc[0]);
    end
    chk("held_td_wait44", 32'(te[0]), 32'd1);
    chk("held_td_pulses44", 32'(pcnt), 32'd1);
    #1 timer_done = 1'b0;
    repeat (40) @(negedge clk);

    #1 timer_done = 1'b1;
    @(negedge clk);
    #1 timer_done = 1'b0;
    repeat (6) @(negedge clk);
    chk("erase44_pix21", {27'd0, er[0], xa, ya},
        {27'd0, 1'b1, 2'd2, 2'd1});
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("async_reset_dut%0d", i), 32'(actv(i)), 32'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("redraw44_start", {28'd0, pl[0], er[0], xa, ya},
        {28'd0, 1'b1, 1'b0, 2'd0, 2'd0});
    repeat (20) @(negedge clk);

    repeat (3000) begin
      @(negedge clk);
      #1 timer_done = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
          chk($sformatf("rand_reset_dut%0d", i), 32'(actv(i)), 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
